// File: rtl/intt_pkg.sv
// Shared constants and FSM encoding for the INTT scheduler block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package intt_pkg;

  // Prime modulus of the coefficient ring.
  localparam int unsigned Q          = 8380417;
  localparam int unsigned N_COEF     = 256;
  localparam int unsigned COEF_WIDTH = 24;
  localparam int unsigned ADDR_WIDTH = 8;
  // One spare bit so N-1 compares never wrap.
  localparam int unsigned CNT_WIDTH  = 9;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD        = 3'd1,
    S_RUN         = 3'd2,
    S_UNLOAD_RD   = 3'd3,
    S_UNLOAD_WAIT = 3'd4,
    S_UNLOAD_OUT  = 3'd5
  } state_t;

endpackage

// File: rtl/intt_ram_mux.sv
// Single-port RAM request mux: INTT core owns the port while running, scheduler otherwise.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the select alone decides ownership.
// Ports: sel_core_i selects core side; sched_*_i / core_*_i request sources; ram_*_o to the RAM.
module intt_ram_mux #(
  parameter int WIDTH = 24,
  parameter int AW    = 8
) (
  input  logic             sel_core_i,
  input  logic [AW-1:0]    sched_addr_i,
  input  logic             sched_we_i,
  input  logic [WIDTH-1:0] sched_wdata_i,
  input  logic [AW-1:0]    core_addr_i,
  input  logic             core_we_i,
  input  logic [WIDTH-1:0] core_wdata_i,
  output logic [AW-1:0]    ram_addr_o,
  output logic             ram_we_o,
  output logic [WIDTH-1:0] ram_wdata_o
);

  // core_we outside the run phase never reaches the RAM.
  assign ram_addr_o  = sel_core_i ? core_addr_i  : sched_addr_i;
  assign ram_we_o    = sel_core_i ? core_we_i    : sched_we_i;
  assign ram_wdata_o = sel_core_i ? core_wdata_i : sched_wdata_i;

endmodule

// File: rtl/intt_sched.sv
// INTT job scheduler: loads N coefficients into RAM, hands RAM to the core, streams results out.
// Latency: core_start 1 cycle after last load; first out_valid 3 cycles after core_done.
// Backpressure: in_ready low outside load; out_data held while out_valid & !out_ready.
// Ports: in_* load stream, out_* result stream, core_* core handshake and memory port,
//        ram_* single-port RAM (1-cycle read), busy / range_err status.
// Optional macro INTT_SCHED_RANGE_CHK_EN: reduce load words >= Q and flag them on range_err.
module intt_sched
  import intt_pkg::*;
#(
  parameter int WIDTH = COEF_WIDTH,
  parameter int N     = N_COEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy,
  output logic                  range_err,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic                  core_we,
  input  logic [WIDTH-1:0]      core_wdata,
  output logic [WIDTH-1:0]      core_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   core_start_q, core_start_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;

  logic                   load_phase;
  logic                   load_hs;
  logic                   first_hs;
  logic [ADDR_WIDTH-1:0]  sched_addr;
  logic [WIDTH-1:0]       load_wdata;

  assign load_phase = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign load_hs    = load_phase && in_valid;
  assign first_hs   = (state_q == S_IDLE) && in_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_start_d = core_start_q;
    out_data_d   = out_data_q;
    sched_addr   = cnt_q[ADDR_WIDTH-1:0];
    case (state_q)
      S_IDLE: begin
        sched_addr = '0;
        if (in_valid) begin
          cnt_d   = CNT_WIDTH'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q == LAST) begin
            cnt_d        = '0;
            core_start_d = 1'b1;
            state_d      = S_RUN;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      S_RUN: begin
        if (core_done) begin
          core_start_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_UNLOAD_RD;
        end
      end
      S_UNLOAD_RD: begin
        state_d = S_UNLOAD_WAIT;
      end
      S_UNLOAD_WAIT: begin
        // Read issued last cycle; RAM data is valid now.
        out_data_d = ram_rdata;
        state_d    = S_UNLOAD_OUT;
      end
      S_UNLOAD_OUT: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = S_UNLOAD_RD;
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        cnt_d        = '0;
        core_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      out_data_q   <= out_data_d;
    end
  end

`ifdef INTT_SCHED_RANGE_CHK_EN
  localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
  logic oor;
  logic range_err_q, range_err_d;

  // Inputs are below 2Q, so one subtraction brings them into range.
  assign oor        = in_data >= QW;
  assign load_wdata = oor ? (in_data - QW) : in_data;

  // A new job clears the flag, but its own first word may set it again.
  always_comb begin
    range_err_d = range_err_q;
    if (first_hs) begin
      range_err_d = oor;
    end else if (load_hs && oor) begin
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign range_err = range_err_q;
`else
  assign load_wdata = in_data;
  assign range_err  = 1'b0;
`endif

  // Reset gates the combinational load path so nothing is written while held in reset.
  assign in_ready   = load_phase && rst_n;
  assign out_valid  = (state_q == S_UNLOAD_OUT);
  assign out_data   = out_data_q;
  assign busy       = (state_q != S_IDLE);
  assign core_start = core_start_q;
  assign core_rdata = ram_rdata;

  intt_ram_mux #(
    .WIDTH (WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_ram_mux (
    .sel_core_i    (state_q == S_RUN),
    .sched_addr_i  (sched_addr),
    .sched_we_i    (load_hs && rst_n),
    .sched_wdata_i (load_wdata),
    .core_addr_i   (core_addr),
    .core_we_i     (core_we),
    .core_wdata_i  (core_wdata),
    .ram_addr_o    (ram_addr),
    .ram_we_o      (ram_we),
    .ram_wdata_o   (ram_wdata)
  );

endmodule

// File: doc/intt_sched.md
INTT_SCHED -- requirements
Module: intt_sched

Interface
REQ-001 Parameter WIDTH, default 24, coefficient width in bits.
REQ-002 Parameter N, default 256, coefficients per job; address width is 8 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid / in_ready / in_data  input / output / input  1 / 1 / WIDTH  load stream of coefficients, index 0 first.
REQ-006 out_valid / out_ready / out_data  output / input / output  1 / 1 / WIDTH  result stream, index 0 first.
REQ-007 busy  output  1  high in every state except S_IDLE.
REQ-008 range_err  output  1  sticky out-of-range input flag.
REQ-009 core_start / core_done  output / input  1 / 1  handshake to the INTT core.
REQ-010 core_addr[8] / core_we[1] / core_wdata[WIDTH]  inputs  core memory request port.
REQ-011 core_rdata  output  WIDTH  core read data.
REQ-012 ram_addr[8] / ram_we[1] / ram_wdata[WIDTH]  outputs; ram_rdata[WIDTH] input  single-port RAM with 1-cycle synchronous read.

Function
REQ-013 FSM states SHALL be S_IDLE, S_LOAD, S_RUN, S_UNLOAD_RD, S_UNLOAD_WAIT, S_UNLOAD_OUT.
REQ-014 S_IDLE: in_ready=1; the first in_valid&in_ready writes index 0, sets cnt=1 and moves to S_LOAD.
REQ-015 S_LOAD: in_ready=1; each handshake writes in_data to ram[cnt] in the same cycle (ram_we=1), cnt+1; the handshake at cnt=N-1 moves to S_RUN with cnt=0.
REQ-016 core_start SHALL assert on the first S_RUN cycle (registered) and hold high until core_done is sampled high.
REQ-017 In S_RUN the RAM port SHALL be driven combinationally from core_addr/core_we/core_wdata; core_rdata=ram_rdata always; in every other state ram_* come from the scheduler and core_we is ignored.
REQ-018 core_done high in S_RUN: next cycle core_start=0, cnt=0, state S_UNLOAD_RD.
REQ-019 S_UNLOAD_RD: ram_addr=cnt, ram_we=0, then S_UNLOAD_WAIT; S_UNLOAD_WAIT: ram_rdata registered into out_data, then S_UNLOAD_OUT.
REQ-020 S_UNLOAD_OUT: out_valid=1 and out_data stable until out_ready; on handshake cnt+1 and S_UNLOAD_RD, or S_IDLE if cnt=N-1.
REQ-021 in_ready SHALL be 0 in S_RUN and all unload states; in_valid there is ignored and writes nothing.
REQ-022 out_valid SHALL be 0 outside S_UNLOAD_OUT; out_ready there is ignored.
REQ-023 Back-to-back jobs: in_ready=1 in the cycle after the last output handshake.
REQ-024 cnt is 9 bits; it never exceeds N-1 in any state.
REQ-025 core_done high while in S_IDLE/S_LOAD/unload states SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force: state S_IDLE, cnt=0, core_start=0, out_valid=0, out_data=0, range_err=0, scheduler ram_we=0.
REQ-027 Reset mid-load or mid-run abandons the job; RAM contents are not cleared.

Configuration
REQ-028 Macro INTT_SCHED_RANGE_CHK_EN defined: a load word >= Q (8380417) is written as in_data-Q, and range_err sets and stays set until reset or the next S_IDLE->S_LOAD transition.
REQ-029 Macro undefined: load words are written verbatim and range_err is tied to 0.

Structure
REQ-030 Q, N_COEF, COEF_WIDTH and the FSM state encoding SHALL live in shared package intt_pkg.
REQ-031 The RAM port mux SHALL be one sub-module, intt_ram_mux: combinational, with a select input driven from (state==S_RUN).

Verification
REQ-032 Load 0..255 with in_valid held high -> 256 consecutive in_ready cycles, core_start rises exactly 1 cycle after the last handshake.
REQ-033 Behavioural core model: done after 100 cycles, writing ram[k]=k+1 -> core_start falls 1 cycle after done; outputs 1..256 in order; out_valid first asserts 3 cycles after done.
REQ-034 out_ready toggled 1-0-1 randomly with stalls up to 5 cycles -> out_data held stable while stalled; no word dropped or duplicated.
REQ-035 in_valid=1 with data 0xABCDEF during S_RUN -> in_ready=0 and ram not written by the scheduler.
REQ-036 With INTT_SCHED_RANGE_CHK_EN defined, load word 8380420 at index 7 -> ram[7]=3 and range_err=1 through unload; without the macro -> ram[7]=8380420 and range_err=0.
REQ-037 rst_n pulsed low at load index 100, then a full clean job -> busy=0 immediately; the following job outputs match the model.
